// File: rtl/lock_seq_pkg.sv
// Shared types and default constants for the CCC lock / reset sequencer.
// Imported by the sequencer top and available to other CCC glue blocks.
package lock_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      QUALIFY   = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_e;

   localparam int DEF_SYNC_STAGES        = 2;
   localparam int DEF_LOCK_STABLE_CYCLES = 1024;
   localparam int DEF_RESET_HOLD_CYCLES  = 16;
   localparam int DEF_CNT_W              = 8;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchronizer for async flags from the CCC.
// Synchronous active-low reset clears the whole chain.
module sync_bit #(
   parameter int N = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic d_i,
   output logic q_o
);

   logic [N-1:0] sync_q;

   // Shift the async input through the flop chain
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[N-2:0], d_i};
      end
   end

   assign q_o = sync_q[N-1];

endmodule

// File: rtl/lock_reset_sequencer.sv
// Qualifies CCC LOCK, then releases a registered system reset.
// Tracks lock losses seen in RUN with a sticky flag and saturating count.
module lock_reset_sequencer
   import lock_seq_pkg::*;
#(
   parameter int SYNC_STAGES        = DEF_SYNC_STAGES,
   parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
   parameter int RESET_HOLD_CYCLES  = DEF_RESET_HOLD_CYCLES,
   parameter int CNT_W              = DEF_CNT_W
) (
   input  logic             CLK,
   input  logic             RESETN,
   input  logic             LOCK,
   input  logic             FORCE_RST,
   input  logic             CLR_STICKY,
   output logic             SYS_RESETN,
   output logic             READY,
   output logic             LOCK_LOST,
   output logic [CNT_W-1:0] LOCK_LOST_CNT
);

   localparam int PW =
      $clog2(max2(LOCK_STABLE_CYCLES, RESET_HOLD_CYCLES) + 1);
   localparam logic [PW-1:0] QUAL_LAST = PW'(LOCK_STABLE_CYCLES - 1);
   localparam logic [PW-1:0] HOLD_LAST = PW'(RESET_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic             lock_s;
   state_e           state_q, state_d;
   logic [PW-1:0]    cnt_q, cnt_d;
   logic             sys_resetn_q;
   logic             ready_q;
   logic             loss;
   logic             lost_q, lost_d;
   logic [CNT_W-1:0] lost_cnt_q, lost_cnt_d;

   // Synchronizer depends only on RESETN, never on the sequenced reset
   sync_bit #(
      .N(SYNC_STAGES)
   ) u_lock_sync (
      .clk_i (CLK),
      .rst_ni(RESETN),
      .d_i   (LOCK),
      .q_o   (lock_s)
   );

   // Next-state and phase counter; lock loss outranks FORCE_RST
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      loss    = 1'b0;
      unique case (state_q)
         WAIT_LOCK: begin
            if (lock_s) begin
               state_d = QUALIFY;
               cnt_d   = '0;
            end
         end
         QUALIFY: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == QUAL_LAST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         HOLD: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
            end else if (FORCE_RST) begin
               cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
               state_d = RUN;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + PW'(1);
            end
         end
         RUN: begin
            if (!lock_s) begin
               state_d = WAIT_LOCK;
               cnt_d   = '0;
               loss    = 1'b1;
            end else if (FORCE_RST) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
         end
      endcase
   end

   // FSM registers; outputs decoded from next state so they track it
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state_q      <= WAIT_LOCK;
         cnt_q        <= '0;
         sys_resetn_q <= 1'b0;
         ready_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sys_resetn_q <= (state_d == RUN);
         ready_q      <= (state_d == RUN);
      end
   end

   // Clear first, then a same-edge loss sets on top of it
   always_comb begin
      lost_d     = CLR_STICKY ? 1'b0 : lost_q;
      lost_cnt_d = CLR_STICKY ? '0 : lost_cnt_q;
      if (loss) begin
         lost_d = 1'b1;
         if (lost_cnt_d != CNT_MAX) begin
            lost_cnt_d = lost_cnt_d + CNT_W'(1);
         end
      end
   end

   // Sticky loss flag and saturating loss counter
   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         lost_q     <= 1'b0;
         lost_cnt_q <= '0;
      end else begin
         lost_q     <= lost_d;
         lost_cnt_q <= lost_cnt_d;
      end
   end

   assign SYS_RESETN    = sys_resetn_q;
   assign READY         = ready_q;
   assign LOCK_LOST     = lost_q;
   assign LOCK_LOST_CNT = lost_cnt_q;

endmodule

// File: tb/tb_lock_reset_sequencer.sv
// Directed bench for lock_reset_sequencer (2/8/4 stages, 2-bit count).
// Expected values are hand-derived edge counts from the first LOCK sample.
module tb_lock_reset_sequencer;

   logic       clk;
   logic       resetn;
   logic       lock;
   logic       force_rst;
   logic       clr_sticky;
   logic       sys_resetn;
   logic       ready;
   logic       lock_lost;
   logic [1:0] lock_lost_cnt;

   int errors = 0;
   int checks = 0;

   lock_reset_sequencer #(
      .SYNC_STAGES       (2),
      .LOCK_STABLE_CYCLES(8),
      .RESET_HOLD_CYCLES (4),
      .CNT_W             (2)
   ) dut (
      .CLK          (clk),
      .RESETN       (resetn),
      .LOCK         (lock),
      .FORCE_RST    (force_rst),
      .CLR_STICKY   (clr_sticky),
      .SYS_RESETN   (sys_resetn),
      .READY        (ready),
      .LOCK_LOST    (lock_lost),
      .LOCK_LOST_CNT(lock_lost_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag,
                          input logic s,
                          input logic r);
      chk({tag, "_sys"}, {31'd0, sys_resetn}, {31'd0, s});
      chk({tag, "_rdy"}, {31'd0, ready}, {31'd0, r});
   endtask

   task automatic chk_log(input string tag,
                          input logic l,
                          input logic [1:0] c);
      chk({tag, "_lost"}, {31'd0, lock_lost}, {31'd0, l});
      chk({tag, "_cnt"}, {30'd0, lock_lost_cnt}, {30'd0, c});
   endtask

   initial begin
      resetn     = 1'b0;
      lock       = 1'b1;
      force_rst  = 1'b0;
      clr_sticky = 1'b0;

      // 1. power-up: 3 reset edges, release 15 edges later
      tick(3);
      chk_out("rst", 1'b0, 1'b0);
      chk_log("rst", 1'b0, 2'd0);
      resetn = 1'b1;
      tick(14);
      chk_out("pwr_e14", 1'b0, 1'b0);
      tick(1);
      chk_out("pwr_e15", 1'b1, 1'b1);

      // 3. losses in RUN, count saturates at 3
      lock = 1'b0;
      tick(2);
      chk_out("loss1_e2", 1'b1, 1'b1);
      tick(1);
      chk_out("loss1_e3", 1'b0, 1'b0);
      chk_log("loss1", 1'b1, 2'd1);
      lock = 1'b1;
      tick(14);
      chk_out("relock1_e14", 1'b0, 1'b0);
      tick(1);
      chk_out("relock1_e15", 1'b1, 1'b1);
      for (int i = 2; i <= 5; i++) begin
         lock = 1'b0;
         tick(3);
         chk_out("lossn", 1'b0, 1'b0);
         chk_log("lossn", 1'b1, (i > 3) ? 2'd3 : 2'(i));
         if (i < 5) begin
            lock = 1'b1;
            tick(15);
            chk_out("relockn", 1'b1, 1'b1);
         end
      end

      // 2. glitch: 5 high, 1 low, then high -> release 15 after regain
      lock = 1'b1;
      tick(5);
      lock = 1'b0;
      tick(1);
      lock = 1'b1;
      tick(9);
      chk_out("glitch_orig", 1'b0, 1'b0);
      tick(5);
      chk_out("glitch_e14", 1'b0, 1'b0);
      tick(1);
      chk_out("glitch_e15", 1'b1, 1'b1);

      // clear alone, in RUN
      clr_sticky = 1'b1;
      tick(1);
      clr_sticky = 1'b0;
      chk_log("clr", 1'b0, 2'd0);
      chk_out("clr", 1'b1, 1'b1);

      // 4. FORCE_RST in RUN: 4-edge hold, no event logged
      force_rst = 1'b1;
      tick(1);
      force_rst = 1'b0;
      chk_out("force_e1", 1'b0, 1'b0);
      tick(3);
      chk_out("force_e4", 1'b0, 1'b0);
      tick(1);
      chk_out("force_e5", 1'b1, 1'b1);
      chk_log("force", 1'b0, 2'd0);

      // FORCE_RST during HOLD restarts the hold
      force_rst = 1'b1;
      tick(1);
      force_rst = 1'b0;
      tick(2);
      force_rst = 1'b1;
      tick(1);
      force_rst = 1'b0;
      tick(3);
      chk_out("rehold_e3", 1'b0, 1'b0);
      tick(1);
      chk_out("rehold_e4", 1'b1, 1'b1);

      // 5a. FORCE_RST on the edge lock_s falls: loss wins
      lock = 1'b0;
      tick(2);
      force_rst = 1'b1;
      tick(1);
      force_rst = 1'b0;
      chk_out("frc_loss", 1'b0, 1'b0);
      chk_log("frc_loss", 1'b1, 2'd1);
      lock = 1'b1;
      tick(14);
      chk_out("frc_relock_e14", 1'b0, 1'b0);
      tick(1);
      chk_out("frc_relock_e15", 1'b1, 1'b1);

      // 5b. CLR_STICKY on the loss edge: set wins, count = 1
      lock = 1'b0;
      tick(2);
      clr_sticky = 1'b1;
      tick(1);
      clr_sticky = 1'b0;
      chk_out("clr_loss", 1'b0, 1'b0);
      chk_log("clr_loss", 1'b1, 2'd1);
      lock = 1'b1;
      tick(15);
      chk_out("clr_relock", 1'b1, 1'b1);

      // 6. reset mid-operation in RUN, then full requalification
      resetn = 1'b0;
      tick(1);
      resetn = 1'b1;
      chk_out("midrst", 1'b0, 1'b0);
      chk_log("midrst", 1'b0, 2'd0);
      tick(14);
      chk_out("midrst_e14", 1'b0, 1'b0);
      tick(1);
      chk_out("midrst_e15", 1'b1, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
